// File: rtl/control_sequencer_pkg.sv
// Shared CPU definitions: opcodes, control-word bit map, idle word, T-state encoding.
// Imported by the sequencer top and its T-state counter.
package control_sequencer_pkg;

  localparam int NUM_T  = 5;
  localparam int OPC_W  = 4;
  localparam int CTRL_W = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bit positions in the control word; _N strobes are active-low.
  localparam logic [3:0] CTL_HLT  = 4'd15;
  localparam logic [3:0] CTL_MI_N = 4'd14;
  localparam logic [3:0] CTL_RI   = 4'd13;
  localparam logic [3:0] CTL_RO_N = 4'd12;
  localparam logic [3:0] CTL_IO_N = 4'd11;
  localparam logic [3:0] CTL_II_N = 4'd10;
  localparam logic [3:0] CTL_AI_N = 4'd9;
  localparam logic [3:0] CTL_AO_N = 4'd8;
  localparam logic [3:0] CTL_EO_N = 4'd7;
  localparam logic [3:0] CTL_SU   = 4'd6;
  localparam logic [3:0] CTL_BI_N = 4'd5;
  localparam logic [3:0] CTL_OI_N = 4'd4;
  localparam logic [3:0] CTL_CE   = 4'd3;
  localparam logic [3:0] CTL_CO_N = 4'd2;
  localparam logic [3:0] CTL_J_N  = 4'd1;
  localparam logic [3:0] CTL_FI   = 4'd0;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 16'h5FB6;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } tstate_e;

  // Drive one strobe to its active level, whatever its polarity.
  function automatic logic [CTRL_W-1:0] strobe(input logic [CTRL_W-1:0] w,
                                               input logic [3:0]        idx);
    logic [CTRL_W-1:0] r;
    r      = w;
    r[idx] = ~CTRL_IDLE[idx];
    return r;
  endfunction

endpackage

// File: rtl/control_sequencer_tstate_counter.sv
// T-state counter T0..T(NUM_T-1); sync clr; advances only when en; wrap forces T0 next.
// Latency: new state one clk after the decision; no backpressure beyond en.
module tstate_counter
  import control_sequencer_pkg::*;
#(
  parameter int NUM_T = control_sequencer_pkg::NUM_T
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       wrap,
  output logic [2:0] tstate
);

  localparam tstate_e LAST_T = tstate_e'(NUM_T - 1);

  tstate_e state_q;
  tstate_e state_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      if (wrap || (state_q == LAST_T)) begin
        state_d = T0;
      end else begin
        case (state_q)
          T0:      state_d = T1;
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          default: state_d = T0;
        endcase
      end
    end
  end

  assign tstate = state_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: decodes (tstate, opcode, flags) into the 16-bit control word.
// ctrl is combinational (zero latency); run=0 pauses with idle strobes; HLT freezes until clr.
// Optional SEQ_EARLY_END_EN: wrap to T0 right after an instruction's last non-idle step.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NUM_T = control_sequencer_pkg::NUM_T,
  parameter int OPC_W = control_sequencer_pkg::OPC_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              run,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [CTRL_W-1:0] ctrl,
  output logic [2:0]        tstate,
  output logic              halted
);

  logic              halt_q;
  logic              step_en;
  logic              halt_set;
  logic              early_wrap;
  logic [CTRL_W-1:0] ucode;
  tstate_e           t;

  assign step_en  = run & ~halt_q;
  assign t        = tstate_e'(tstate);
  assign halt_set = step_en && (t == T2) && (opcode == OP_HLT);

  tstate_counter #(.NUM_T(NUM_T)) u_tstate_counter (
    .clk    (clk),
    .clr    (clr),
    .en     (step_en),
    .wrap   (early_wrap),
    .tstate (tstate)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      halt_q <= 1'b0;
    end else if (halt_set) begin
      halt_q <= 1'b1;
    end
  end

  assign halted = halt_q;

  // Each step enables at most one bus driver (co/ro/io/ao/eo).
  always_comb begin
    ucode = CTRL_IDLE;
    case (t)
      T0: begin
        ucode = strobe(ucode, CTL_CO_N);
        ucode = strobe(ucode, CTL_MI_N);
      end
      T1: begin
        ucode = strobe(ucode, CTL_RO_N);
        ucode = strobe(ucode, CTL_II_N);
        ucode = strobe(ucode, CTL_CE);
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ucode = strobe(ucode, CTL_IO_N);
            ucode = strobe(ucode, CTL_MI_N);
          end
          OP_LDI: begin
            ucode = strobe(ucode, CTL_IO_N);
            ucode = strobe(ucode, CTL_AI_N);
          end
          OP_JMP: begin
            ucode = strobe(ucode, CTL_IO_N);
            ucode = strobe(ucode, CTL_J_N);
          end
          OP_JC: begin
            if (flag_c) begin
              ucode = strobe(ucode, CTL_IO_N);
              ucode = strobe(ucode, CTL_J_N);
            end
          end
          OP_JZ: begin
            if (flag_z) begin
              ucode = strobe(ucode, CTL_IO_N);
              ucode = strobe(ucode, CTL_J_N);
            end
          end
          OP_OUT: begin
            ucode = strobe(ucode, CTL_AO_N);
            ucode = strobe(ucode, CTL_OI_N);
          end
          OP_HLT: ucode = strobe(ucode, CTL_HLT);
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            ucode = strobe(ucode, CTL_RO_N);
            ucode = strobe(ucode, CTL_AI_N);
          end
          OP_ADD, OP_SUB: begin
            ucode = strobe(ucode, CTL_RO_N);
            ucode = strobe(ucode, CTL_BI_N);
          end
          OP_STA: begin
            ucode = strobe(ucode, CTL_AO_N);
            ucode = strobe(ucode, CTL_RI);
          end
          default: ;
        endcase
      end
      T4: begin
        if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
          ucode = strobe(ucode, CTL_EO_N);
          ucode = strobe(ucode, CTL_AI_N);
          ucode = strobe(ucode, CTL_FI);
          if (opcode == OP_SUB) begin
            ucode = strobe(ucode, CTL_SU);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    early_wrap = 1'b0;
`ifdef SEQ_EARLY_END_EN
    // HLT never wraps early so both builds freeze at the same T-state.
    case (t)
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_HLT: early_wrap = 1'b0;
          default:                                early_wrap = 1'b1;
        endcase
      end
      T3: early_wrap = (opcode == OP_LDA) || (opcode == OP_STA);
      default: early_wrap = 1'b0;
    endcase
`else
    early_wrap = 1'b0;
`endif
  end

  // clr beats halt, halt beats run.
  always_comb begin
    ctrl = ucode;
    if (clr) begin
      ctrl = CTRL_IDLE;
    end else if (halt_q) begin
      ctrl = strobe(CTRL_IDLE, CTL_HLT);
    end else if (!run) begin
      ctrl = CTRL_IDLE;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: table-driven microcode vectors, hand sequences, random invariants.
module tb_control_sequencer;

  localparam logic [15:0] IDLE = 16'h5FB6;
  localparam logic [15:0] M_HLT = 16'h8000, M_MI = 16'h4000, M_RI = 16'h2000, M_RO = 16'h1000;
  localparam logic [15:0] M_IO  = 16'h0800, M_II = 16'h0400, M_AI = 16'h0200, M_AO = 16'h0100;
  localparam logic [15:0] M_EO  = 16'h0080, M_SU = 16'h0040, M_BI = 16'h0020, M_OI = 16'h0010;
  localparam logic [15:0] M_CE  = 16'h0008, M_CO = 16'h0004, M_J  = 16'h0002, M_FI = 16'h0001;
`ifdef SEQ_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, run, flag_c, flag_z;
  logic [3:0]  opcode;
  logic [15:0] ctrl;
  logic [2:0]  tstate;
  logic        halted;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .tstate (tstate),
    .halted (halted)
  );

  typedef struct { logic [15:0] ctrl; logic [2:0] t; logic h; } exp_t;
  typedef struct { logic [3:0] op; logic fc; logic fz; logic [15:0] m2; logic [15:0] m3; logic [15:0] m4; int last; } vec_t;

  exp_t sb[$];
  vec_t tbl[16];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare on the falling edge.
  task automatic cyc(input string name, input logic [3:0] op, input logic fc, input logic fz,
                     input logic r, input logic c, input logic [15:0] e_ctrl,
                     input logic [2:0] e_t, input logic e_h);
    exp_t e;
    exp_t g;
    opcode = op; flag_c = fc; flag_z = fz; run = r; clr = c;
    e.ctrl = e_ctrl; e.t = e_t; e.h = e_h;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk({name, " ctrl"}, ctrl, g.ctrl);
    chk({name, " tstate"}, {13'd0, tstate}, {13'd0, g.t});
    chk({name, " halted"}, {15'd0, halted}, {15'd0, g.h});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nl;
    int          lows;
    logic [15:0] m;
    logic [3:0]  op;

    tbl[0]  = '{4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2};
    tbl[1]  = '{4'h1, 1'b0, 1'b0, M_IO | M_MI, M_RO | M_AI, 16'h0, 3};
    tbl[2]  = '{4'h2, 1'b1, 1'b0, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI, 4};
    tbl[3]  = '{4'h3, 1'b0, 1'b1, M_IO | M_MI, M_RO | M_BI, M_EO | M_AI | M_FI | M_SU, 4};
    tbl[4]  = '{4'h4, 1'b0, 1'b0, M_IO | M_MI, M_AO | M_RI, 16'h0, 3};
    tbl[5]  = '{4'h5, 1'b0, 1'b0, M_IO | M_AI, 16'h0, 16'h0, 2};
    tbl[6]  = '{4'h6, 1'b0, 1'b0, M_IO | M_J, 16'h0, 16'h0, 2};
    tbl[7]  = '{4'h7, 1'b1, 1'b0, M_IO | M_J, 16'h0, 16'h0, 2};
    tbl[8]  = '{4'h7, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2};
    tbl[9]  = '{4'h7, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 2};
    tbl[10] = '{4'h8, 1'b0, 1'b1, M_IO | M_J, 16'h0, 16'h0, 2};
    tbl[11] = '{4'h8, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2};
    tbl[12] = '{4'h9, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 2};
    tbl[13] = '{4'hA, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2};
    tbl[14] = '{4'hD, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 2};
    tbl[15] = '{4'hE, 1'b0, 1'b0, M_AO | M_OI, 16'h0, 16'h0, 2};

    clr = 1'b1; run = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, then clr held two cycles from T3.
    cyc("rst", 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, 3'd0, 1'b0);
    cyc("pre_t0", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_CO | M_MI), 3'd0, 1'b0);
    cyc("pre_t1", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_RO | M_II | M_CE), 3'd1, 1'b0);
    cyc("pre_t2", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_IO | M_MI), 3'd2, 1'b0);
    cyc("clr_a", 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, 3'd3, 1'b0);
    cyc("clr_b", 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, 3'd0, 1'b0);

    // Microcode table; opcode is deliberately wrong during fetch.
    for (int i = 0; i < 16; i++) begin
      nl = EARLY ? tbl[i].last : 4;
      for (int t = 0; t <= nl; t++) begin
        case (t)
          0:       m = M_CO | M_MI;
          1:       m = M_RO | M_II | M_CE;
          2:       m = tbl[i].m2;
          3:       m = tbl[i].m3;
          default: m = tbl[i].m4;
        endcase
        op = (t < 2) ? ~tbl[i].op : tbl[i].op;
        cyc($sformatf("op%h fc%0d fz%0d T%0d", tbl[i].op, tbl[i].fc, tbl[i].fz, t),
            op, tbl[i].fc, tbl[i].fz, 1'b1, 1'b0, IDLE ^ m, 3'(t), 1'b0);
      end
    end

    // Pause LDA in T3, then resume the same step.
    cyc("pause_t0", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_CO | M_MI), 3'd0, 1'b0);
    cyc("pause_t1", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_RO | M_II | M_CE), 3'd1, 1'b0);
    cyc("pause_t2", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_IO | M_MI), 3'd2, 1'b0);
    for (int k = 0; k < 3; k++)
      cyc("paused_t3", 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 3'd3, 1'b0);
    cyc("resume_t3", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_RO | M_AI), 3'd3, 1'b0);
    if (!EARLY)
      cyc("resume_t4", 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, IDLE, 3'd4, 1'b0);

    // HLT: freeze regardless of run, only clr exits.
    cyc("hlt_t0", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_CO | M_MI), 3'd0, 1'b0);
    cyc("hlt_t1", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_RO | M_II | M_CE), 3'd1, 1'b0);
    cyc("hlt_t2", 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ M_HLT, 3'd2, 1'b0);
    for (int k = 0; k < 10; k++)
      cyc("halted", 4'h2, 1'b1, 1'b1, (k % 3) != 0, 1'b0, IDLE ^ M_HLT, 3'd3, 1'b1);
    cyc("halt_clr", 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, 3'd3, 1'b1);
    cyc("halt_exit", 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, IDLE ^ (M_CO | M_MI), 3'd0, 1'b0);

    // Random opcodes/flags/run/clr: bus-driver and PC-count invariants.
    for (int n = 0; n < 2000; n++) begin
      opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      run    = ($urandom_range(0, 3) != 0);
      clr    = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      lows = 0;
      if (!ctrl[2])  lows++;
      if (!ctrl[12]) lows++;
      if (!ctrl[11]) lows++;
      if (!ctrl[8])  lows++;
      if (!ctrl[7])  lows++;
      if (lows > 1)
        chk("rand_bus_drivers", {ctrl[12:11], ctrl[8:7], 9'd0, ctrl[2], 2'd0}, 16'h1B04);
      if (ctrl[3] && (tstate != 3'd1))
        chk("rand_ce_outside_t1", {13'd0, tstate}, 16'd1);
      if (clr) chk("rand_clr_idle", ctrl, IDLE);
      else if (halted) chk("rand_halt_word", ctrl, IDLE ^ M_HLT);
      else if (!run) chk("rand_pause_idle", ctrl, IDLE);
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
